mul_arbiter: RTL

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: two-requester round-robin front end for an external shift-add multiplier.
//
// A winner is picked in IDLE, its operands are latched onto mul_a/mul_b, the multiplier is
// reset (CLEAR) and started (START), and the block waits for mul_ready (WAIT). In DONE the
// product is captured into result and the winner's done line pulses for one cycle.
//
// Optional feature: define MUL_ARB_TIMEOUT_EN to bound WAIT to TIMEOUT cycles. On expiry the
// operation completes with err=1 and result=0. Without the macro err is tied low and WAIT
// is unbounded.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/req1           level requests, held until the matching done pulse
//   a0,b0 / a1,b1       operands of requester 0 / 1
//   gnt0/gnt1           registered grant, one-hot or zero, stable from CLEAR through DONE
//   done0/done1         one-cycle completion pulse to the granted requester
//   result              last captured product, held until the next DONE
//   err                 timeout flag, valid during the done pulse
//   busy                high in every state except IDLE
//   mul_rst, mul_run    multiplier reset (also high while rst) and start pulse
//   mul_a, mul_b        latched operands, frozen while busy
//   mul_ready           multiplier finished (level, cleared by mul_rst)
//   mul_product         multiplier product

module mul_arbiter #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned TIMEOUT = 40
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req0,
   input  logic               req1,
   input  logic [WIDTH-1:0]   a0,
   input  logic [WIDTH-1:0]   b0,
   input  logic [WIDTH-1:0]   a1,
   input  logic [WIDTH-1:0]   b1,
   output logic               gnt0,
   output logic               gnt1,
   output logic               done0,
   output logic               done1,
   output logic [2*WIDTH-1:0] result,
   output logic               err,
   output logic               busy,
   output logic               mul_rst,
   output logic               mul_run,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic               mul_ready,
   input  logic [2*WIDTH-1:0] mul_product
);

   typedef enum logic [2:0] {StIdle, StClear, StStart, StWait, StDone} state_e;

   state_e               state_q;
   logic                 last_q;   // requester served last; 1 after reset so requester 0 leads
   logic                 win_q;    // requester currently granted
   logic                 gnt0_q, gnt1_q;
   logic                 done0_q, done1_q;
   logic                 clear_q;
   logic                 run_q;
   logic [2*WIDTH-1:0]   result_q;
   logic [WIDTH-1:0]     mul_a_q, mul_b_q;
   logic                 pick1;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   logic [CntW-1:0]      cnt_q;
   logic                 err_q;
`endif

   // Requester 1 wins when it is alone, or when both request and 0 was served last.
   always_comb begin
      pick1 = req1 & (~req0 | ~last_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         gnt0_q   <= 1'b0;
         gnt1_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         clear_q  <= 1'b0;
         run_q    <= 1'b0;
         result_q <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         cnt_q    <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req0 || req1) begin
                  win_q   <= pick1;
                  gnt0_q  <= ~pick1;
                  gnt1_q  <= pick1;
                  mul_a_q <= pick1 ? a1 : a0;
                  mul_b_q <= pick1 ? b1 : b0;
                  clear_q <= 1'b1;
                  state_q <= StClear;
               end
            end
            StClear: begin
               clear_q <= 1'b0;
               run_q   <= 1'b1;
               state_q <= StStart;
            end
            StStart: begin
               run_q   <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
               cnt_q   <= '0;
`endif
               state_q <= StWait;
            end
            StWait: begin
               if (mul_ready) begin
                  result_q <= mul_product;
                  done0_q  <= ~win_q;
                  done1_q  <= win_q;
                  state_q  <= StDone;
`ifdef MUL_ARB_TIMEOUT_EN
               end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
                  done0_q  <= ~win_q;
                  done1_q  <= win_q;
                  state_q  <= StDone;
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
`endif
               end
            end
            StDone: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               gnt0_q  <= 1'b0;
               gnt1_q  <= 1'b0;
               last_q  <= win_q;
`ifdef MUL_ARB_TIMEOUT_EN
               err_q   <= 1'b0;
`endif
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign done0   = done0_q;
   assign done1   = done1_q;
   assign result  = result_q;
   assign busy    = (state_q != StIdle);
   // The multiplier is held in reset for the whole of our own reset as well as during CLEAR.
   assign mul_rst = rst | clear_q;
   assign mul_run = run_q;
   assign mul_a   = mul_a_q;
   assign mul_b   = mul_b_q;
`ifdef MUL_ARB_TIMEOUT_EN
   assign err     = err_q;
`else
   assign err     = 1'b0;
`endif

endmodule
